// File: rtl/pycpu_pkg.sv
// pycpu shared types: opcodes, FSM states, instruction layout.
// Interrupt vectors are used only when PYCPU_INT_EN is defined.
package pycpu_pkg;

  localparam int OP_W  = 4;
  localparam int REG_W = 2;
  localparam int IMM_W = 8;

  localparam logic [15:0] VEC_A = 16'h0004;
  localparam logic [15:0] VEC_B = 16'h0008;

  localparam logic [IMM_W-1:0] RETI_IMM = 8'h01;

  typedef enum logic [OP_W-1:0] {
    OP_NOP = 4'h0,
    OP_LDI = 4'h1,
    OP_LDH = 4'h2,
    OP_MOV = 4'h3,
    OP_ADD = 4'h4,
    OP_SUB = 4'h5,
    OP_AND = 4'h6,
    OP_OR  = 4'h7,
    OP_XOR = 4'h8,
    OP_SHL = 4'h9,
    OP_LD  = 4'hA,
    OP_ST  = 4'hB,
    OP_JMP = 4'hC,
    OP_BZ  = 4'hD,
    OP_BC  = 4'hE,
    OP_SYS = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_HALT
  } state_e;

  typedef struct packed {
    opcode_e          op;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs;
    logic [IMM_W-1:0] imm;
  } instr_t;

  function automatic logic [15:0] sext8(
    input logic [IMM_W-1:0] v
  );
    return {{(16-IMM_W){v[IMM_W-1]}}, v};
  endfunction

endpackage

// File: rtl/pycpu_alu.sv
// pycpu ALU: 16-bit modulo arithmetic, logic and shift.
// C is carry for ADD, borrow for SUB, old bit 15 for SHL.
module pycpu_alu
  import pycpu_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  opcode_e     op,
  output logic [15:0] result,
  output logic        c,
  output logic        z
);

  logic [16:0] wide;

  // result and carry/borrow selection
  always_comb begin
    wide   = '0;
    result = a;
    c      = 1'b0;
    case (op)
      OP_ADD: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[15:0];
        c      = wide[16];
      end
      OP_SUB: begin
        wide   = {1'b0, a} - {1'b0, b};
        result = wide[15:0];
        c      = wide[16];
      end
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_XOR: result = a ^ b;
      OP_SHL: begin
        result = {a[14:0], 1'b0};
        c      = a[15];
      end
      OP_MOV: result = b;
      default: result = a;
    endcase
  end

  assign z = (result == 16'h0000);

endmodule

// File: rtl/pycpu_core.sv
// pycpu core: registers, FETCH/EXEC/HALT FSM, shared bus.
// Define PYCPU_INT_EN to enable the two-level interrupt logic.
module pycpu_core
  import pycpu_pkg::*;
(
  input  logic        clk,
  input  logic        n_rst,
  input  logic        i_inta,
  input  logic        i_intb,
  output logic        o_rw,
  output logic [15:0] o_addr,
  inout  wire  [15:0] io_data,
  inout  wire         io_lock
);

  state_e      state;
  logic [15:0] pc;
  instr_t      ir;
  logic [15:0] regs [4];
  logic        z;
  logic        c;

  logic [15:0] rd_val;
  logic [15:0] rs_val;
  logic [15:0] br_tgt;
  logic [15:0] alu_res;
  logic        alu_c;
  logic        alu_z;
  logic        in_exec;

  assign rd_val  = regs[ir.rd];
  assign rs_val  = regs[ir.rs];
  assign br_tgt  = pc + sext8(ir.imm);
  assign in_exec = (state == S_EXEC);

  pycpu_alu u_alu (
    .a      (rd_val),
    .b      (rs_val),
    .op     (ir.op),
    .result (alu_res),
    .c      (alu_c),
    .z      (alu_z)
  );

`ifdef PYCPU_INT_EN
  logic [15:0] epc;
  logic        sz;
  logic        sc;
  logic        in_svc;
  logic        irq_take;
  logic [15:0] irq_vec;

  assign irq_take = !in_svc && (i_inta || i_intb);
  assign irq_vec  = i_inta ? VEC_A : VEC_B;
`else
  logic unused_irq;
  assign unused_irq = i_inta ^ i_intb;
`endif

  // bus address/direction straight from state and registers
  always_comb begin
    o_rw   = 1'b0;
    o_addr = pc;
    unique case (1'b1)
      in_exec && ir.op == OP_LD: begin
        o_addr = rs_val;
      end
      in_exec && ir.op == OP_ST: begin
        o_rw   = 1'b1;
        o_addr = rd_val;
      end
      default: ;
    endcase
  end

  assign io_data = o_rw ? rs_val : 16'hzzzz;
  assign io_lock = o_rw ? 1'b1 : 1'bz;

  // FSM, register file, flags and PC
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= S_FETCH;
      pc    <= '0;
      ir    <= '0;
      z     <= 1'b0;
      c     <= 1'b0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
`ifdef PYCPU_INT_EN
      epc    <= '0;
      sz     <= 1'b0;
      sc     <= 1'b0;
      in_svc <= 1'b0;
`endif
    end else begin
      unique case (state)
        S_FETCH: begin
`ifdef PYCPU_INT_EN
          if (irq_take) begin
            epc    <= pc;
            sz     <= z;
            sc     <= c;
            in_svc <= 1'b1;
            pc     <= irq_vec;
          end else
`endif
          if (io_lock) begin
            ir    <= instr_t'(io_data);
            pc    <= pc + 16'd1;
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          state <= S_FETCH;
          unique case (ir.op)
            OP_NOP: ;
            OP_LDI: regs[ir.rd] <= {8'h00, ir.imm};
            OP_LDH: regs[ir.rd][15:8] <= ir.imm;
            OP_MOV: regs[ir.rd] <= rs_val;
            OP_ADD, OP_SUB, OP_SHL: begin
              regs[ir.rd] <= alu_res;
              z           <= alu_z;
              c           <= alu_c;
            end
            OP_AND, OP_OR, OP_XOR: begin
              regs[ir.rd] <= alu_res;
              z           <= alu_z;
              c           <= 1'b0;
            end
            OP_LD: begin
              if (io_lock) regs[ir.rd] <= io_data;
              else         state <= S_EXEC;
            end
            OP_ST: ;
            OP_JMP: pc <= rs_val;
            OP_BZ: if (z) pc <= br_tgt;
            OP_BC: if (c) pc <= br_tgt;
            OP_SYS: begin
              if (ir.imm == RETI_IMM) begin
`ifdef PYCPU_INT_EN
                pc     <= epc;
                z      <= sz;
                c      <= sc;
                in_svc <= 1'b0;
`endif
              end else begin
                state <= S_HALT;
              end
            end
          endcase
        end
        S_HALT: begin
`ifdef PYCPU_INT_EN
          if (irq_take) begin
            epc    <= pc;
            sz     <= z;
            sc     <= c;
            in_svc <= 1'b1;
            pc     <= irq_vec;
            state  <= S_FETCH;
          end
`endif
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pycpu_core.sv
// pycpu_core bench: ALU vector table plus bus corner sequences.
// Interrupt sequence is compiled only with PYCPU_INT_EN.
module tb_pycpu_core;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        inta = 1'b0;
  logic        intb = 1'b0;
  logic        lock_ctl = 1'b1;
  wire         rw;
  wire  [15:0] addr;
  wire  [15:0] data;
  wire         lock;

  logic [15:0] mem [256];
  int          wr_cnt = 0;
  logic [15:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic        wr_lock = 1'b0;

  int checks = 0;
  int errors = 0;

  pycpu_core dut (
    .clk     (clk),
    .n_rst   (n_rst),
    .i_inta  (inta),
    .i_intb  (intb),
    .o_rw    (rw),
    .o_addr  (addr),
    .io_data (data),
    .io_lock (lock)
  );

  always #5 clk = ~clk;

  assign data = !rw ? mem[addr[7:0]] : 16'hzzzz;
  assign lock = !rw ? lock_ctl : 1'bz;

  always @(posedge clk) begin
    if (rw) begin
      mem[addr[7:0]] = data;
      wr_cnt  = wr_cnt + 1;
      wr_addr = addr;
      wr_data = data;
      wr_lock = lock;
    end
  end

  typedef struct {
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        z;
    logic        c;
  } vec_t;

  vec_t vt [12];

  function automatic logic [15:0] enc(
    input logic [3:0] op,
    input logic [1:0] rd,
    input logic [1:0] rs,
    input logic [7:0] imm
  );
    return {op, rd, rs, imm};
  endfunction

  task automatic chk(
    input string       name,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
  endtask

  task automatic hold_reset();
    @(negedge clk);
    n_rst    = 1'b0;
    lock_ctl = 1'b1;
    inta     = 1'b0;
    intb     = 1'b0;
    @(negedge clk);
  endtask

  task automatic release_reset();
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic wait_write(
    input  logic [15:0] a,
    input  int          budget,
    output logic        ok
  );
    int start;
    start = wr_cnt;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wr_cnt != start && wr_addr == a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic load_alu(input vec_t v);
    clear_mem();
    mem[0]  = enc(4'h1, 2'd0, 2'd0, v.a[7:0]);
    mem[1]  = enc(4'h2, 2'd0, 2'd0, v.a[15:8]);
    mem[2]  = enc(4'h1, 2'd1, 2'd0, v.b[7:0]);
    mem[3]  = enc(4'h2, 2'd1, 2'd0, v.b[15:8]);
    mem[4]  = enc(v.op, 2'd0, 2'd1, 8'h00);
    mem[5]  = enc(4'h1, 2'd2, 2'd0, 8'h80);
    mem[6]  = enc(4'hB, 2'd2, 2'd0, 8'h00);
    mem[7]  = enc(4'h1, 2'd3, 2'd0, 8'h01);
    mem[8]  = enc(4'hD, 2'd0, 2'd0, 8'h01);
    mem[9]  = enc(4'h1, 2'd3, 2'd0, 8'h00);
    mem[10] = enc(4'h2, 2'd3, 2'd0, 8'h01);
    mem[11] = enc(4'hE, 2'd0, 2'd0, 8'h01);
    mem[12] = enc(4'h2, 2'd3, 2'd0, 8'h00);
    mem[13] = enc(4'h1, 2'd2, 2'd0, 8'h81);
    mem[14] = enc(4'hB, 2'd2, 2'd3, 8'h00);
    mem[15] = 16'hF000;
  endtask

  task automatic load_store_prog();
    clear_mem();
    mem[0] = enc(4'h1, 2'd0, 2'd0, 8'h34);
    mem[1] = enc(4'h2, 2'd0, 2'd0, 8'h12);
    mem[2] = enc(4'h1, 2'd1, 2'd0, 8'h10);
    mem[3] = enc(4'hB, 2'd1, 2'd0, 8'h00);
    mem[4] = 16'hF000;
  endtask

  initial begin
    logic        ok;
    int          base;
    int          bad;
    logic [15:0] fl;

    vt[0]  = '{4'h4, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0};
    vt[1]  = '{4'h4, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1};
    vt[2]  = '{4'h5, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b1};
    vt[3]  = '{4'h5, 16'h1234, 16'h1234, 16'h0000, 1'b1, 1'b0};
    vt[4]  = '{4'h6, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0, 1'b0};
    vt[5]  = '{4'h6, 16'hFF00, 16'h00FF, 16'h0000, 1'b1, 1'b0};
    vt[6]  = '{4'h7, 16'hA000, 16'h0005, 16'hA005, 1'b0, 1'b0};
    vt[7]  = '{4'h8, 16'hBEEF, 16'hBEEF, 16'h0000, 1'b1, 1'b0};
    vt[8]  = '{4'h9, 16'h8001, 16'h0000, 16'h0002, 1'b0, 1'b1};
    vt[9]  = '{4'h9, 16'h8000, 16'h0000, 16'h0000, 1'b1, 1'b1};
    vt[10] = '{4'h3, 16'h1111, 16'hCAFE, 16'hCAFE, 1'b0, 1'b0};
    vt[11] = '{4'h4, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0};

    clear_mem();
    #1;
    chk("rst_addr", {16'h0, addr}, 32'h0);
    chk("rst_rw", {31'h0, rw}, 32'h0);

    for (int k = 0; k < 12; k++) begin
      hold_reset();
      load_alu(vt[k]);
      release_reset();
      wait_write(16'h0081, 200, ok);
      chk($sformatf("v%0d_done", k), {31'h0, ok}, 32'h1);
      chk($sformatf("v%0d_res", k), {16'h0, mem[8'h80]}, {16'h0, vt[k].res});
      fl = {7'b0, vt[k].c, 7'b0, vt[k].z};
      chk($sformatf("v%0d_flags", k), {16'h0, mem[8'h81]}, {16'h0, fl});
    end

    // store: one write cycle with full bus contents
    hold_reset();
    load_store_prog();
    release_reset();
    base = wr_cnt;
    wait_write(16'h0010, 100, ok);
    chk("st_seen", {31'h0, ok}, 32'h1);
    chk("st_addr", {16'h0, wr_addr}, 32'h0010);
    chk("st_data", {16'h0, wr_data}, 32'h1234);
    chk("st_lock", {31'h0, wr_lock}, 32'h1);
    repeat (20) @(negedge clk);
    chk("st_count", wr_cnt - base, 1);

    // reset asserted mid-run during the store cycle
    hold_reset();
    load_store_prog();
    mem[0] = enc(4'h1, 2'd0, 2'd0, 8'h34);
    release_reset();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rw) begin
        ok = 1'b1;
        break;
      end
    end
    chk("mid_wr_seen", {31'h0, ok}, 32'h1);
    n_rst = 1'b0;
    #1;
    chk("mid_addr", {16'h0, addr}, 32'h0);
    chk("mid_rw", {31'h0, rw}, 32'h0);
    chk("mid_bus", {16'h0, data}, {16'h0, mem[0]});
    @(negedge clk);
    n_rst = 1'b1;
    #1;
    chk("mid_fetch0", {16'h0, addr}, 32'h0);
    wait_write(16'h0010, 100, ok);
    chk("mid_rerun", {31'h0, ok}, 32'h1);

    // ADD wraps to zero, BZ +2 taken
    hold_reset();
    clear_mem();
    mem[0] = enc(4'h1, 2'd0, 2'd0, 8'hFF);
    mem[1] = enc(4'h2, 2'd0, 2'd0, 8'hFF);
    mem[2] = enc(4'h1, 2'd1, 2'd0, 8'h01);
    mem[3] = enc(4'h4, 2'd0, 2'd1, 8'h00);
    mem[4] = enc(4'hD, 2'd0, 2'd0, 8'h02);
    mem[5] = enc(4'h1, 2'd3, 2'd0, 8'h50);
    mem[6] = enc(4'hB, 2'd3, 2'd0, 8'h00);
    mem[7] = enc(4'h1, 2'd3, 2'd0, 8'h40);
    mem[8] = enc(4'hB, 2'd3, 2'd0, 8'h00);
    mem[9] = 16'hF000;
    release_reset();
    base = wr_cnt;
    wait_write(16'h0040, 100, ok);
    chk("bz_taken", {31'h0, ok}, 32'h1);
    chk("bz_r0", {16'h0, wr_data}, 32'h0);
    repeat (10) @(negedge clk);
    chk("bz_wcount", wr_cnt - base, 1);

    // LD with three wait states
    hold_reset();
    clear_mem();
    mem[0]     = enc(4'h1, 2'd3, 2'd0, 8'h20);
    mem[1]     = enc(4'hA, 2'd2, 2'd3, 8'h00);
    mem[2]     = enc(4'h1, 2'd1, 2'd0, 8'h30);
    mem[3]     = enc(4'hB, 2'd1, 2'd2, 8'h00);
    mem[4]     = 16'hF000;
    mem[8'h20] = 16'hBEEF;
    release_reset();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (addr == 16'h0020 && !rw) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("ld_seen", {31'h0, ok}, 32'h1);
    lock_ctl = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("ld_wait%0d", i), {16'h0, addr}, 32'h0020);
    end
    lock_ctl = 1'b1;
    wait_write(16'h0030, 50, ok);
    chk("ld_done", {31'h0, ok}, 32'h1);
    chk("ld_data", {16'h0, wr_data}, 32'hBEEF);

    // HALT at 0x0005 parks on 0x0006 with no writes
    hold_reset();
    clear_mem();
    mem[5] = 16'hF000;
    release_reset();
    repeat (14) @(negedge clk);
    base = wr_cnt;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (addr != 16'h0006 || rw) bad = bad + 1;
    end
    chk("halt_stable", bad, 0);
    chk("halt_addr", {16'h0, addr}, 32'h0006);
    chk("halt_nowr", wr_cnt - base, 0);

`ifdef PYCPU_INT_EN
    // both interrupts together: A wins, RETI restores Z/C
    hold_reset();
    clear_mem();
    mem[8'h00] = enc(4'h1, 2'd0, 2'd0, 8'h10);
    mem[8'h01] = enc(4'hC, 2'd0, 2'd0, 8'h00);
    mem[8'h04] = enc(4'h1, 2'd3, 2'd0, 8'h55);
    mem[8'h05] = enc(4'h6, 2'd3, 2'd3, 8'h00);
    mem[8'h06] = 16'hF001;
    mem[8'h08] = enc(4'h1, 2'd3, 2'd0, 8'h99);
    mem[8'h09] = 16'hF001;
    mem[8'h10] = enc(4'h1, 2'd0, 2'd0, 8'hFF);
    mem[8'h11] = enc(4'h2, 2'd0, 2'd0, 8'hFF);
    mem[8'h12] = enc(4'h1, 2'd1, 2'd0, 8'h01);
    mem[8'h13] = enc(4'h4, 2'd0, 2'd1, 8'h00);
    mem[8'h14] = enc(4'hD, 2'd0, 2'd0, 8'h01);
    mem[8'h15] = 16'hF000;
    mem[8'h16] = enc(4'hE, 2'd0, 2'd0, 8'h01);
    mem[8'h17] = 16'hF000;
    mem[8'h18] = enc(4'h1, 2'd2, 2'd0, 8'h40);
    mem[8'h19] = enc(4'hB, 2'd2, 2'd3, 8'h00);
    mem[8'h1A] = 16'hF000;
    release_reset();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (addr == 16'h0014) begin
        ok = 1'b1;
        break;
      end
    end
    chk("irq_arm", {31'h0, ok}, 32'h1);
    inta = 1'b1;
    intb = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (addr == 16'h0004) begin
        ok = 1'b1;
        break;
      end
    end
    chk("irq_vec_a", {31'h0, ok}, 32'h1);
    inta = 1'b0;
    intb = 1'b0;
    wait_write(16'h0040, 100, ok);
    chk("irq_resume", {31'h0, ok}, 32'h1);
    chk("irq_isr", {16'h0, wr_data}, 32'h0055);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", checks, errors);
    $finish;
  end

endmodule
